// File: rtl/alu_sequencer.sv
// alu_sequencer: issues register-file instructions to an external 16-bit ALU and returns results over valid/ready
module alu_sequencer #(
    parameter int DATA_W      = 16,
    parameter int EXEC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr_data,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_in0,
    output logic [DATA_W-1:0] alu_in1,
    input  logic [DATA_W-1:0] alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [2:0]        rsp_rd,
    output logic              rsp_zero,
    output logic              busy
);
    localparam int CW = EXEC_CYCLES > 1 ? $clog2(EXEC_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t            state;
    logic [DATA_W-1:0] rf [8];
    logic [2:0]        rd;
    logic [CW-1:0]     cnt;
    logic              ldi;
    assign ldi         = instr_data[15];
    assign instr_ready = state == IDLE;
    assign busy        = state != IDLE;
    // sequencer FSM: accept and issue operands, wait out the ALU, write back and hold the response
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            alu_op    <= '0;
            alu_in0   <= '0;
            alu_in1   <= '0;
            rd        <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_rd    <= '0;
            rsp_zero  <= 1'b0;
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else
            case (state)
                IDLE: if (instr_valid) begin
                    alu_op  <= ldi ? 3'd0 : instr_data[14:12];
                    alu_in0 <= ldi ? DATA_W'(instr_data[11:0]) : rf[instr_data[8:6]];
                    alu_in1 <= ldi ? '0 : rf[instr_data[5:3]];
                    rd      <= ldi ? instr_data[14:12] : instr_data[11:9];
                    cnt     <= CW'(EXEC_CYCLES - 1);
                    state   <= EXEC;
                end
                EXEC: if (cnt == '0) begin
                    rf[rd]    <= alu_out;
                    rsp_data  <= alu_out;
                    rsp_rd    <= rd;
                    rsp_zero  <= alu_out == '0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end else
                    cnt <= cnt - 1'b1;
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed checks of alu_sequencer with a behavioural ALU, EXEC_CYCLES 1 and 3
module tb_alu_sequencer;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;
    int n_chk = 0, n_pass = 0;

    logic        iv = 0, ir, rv, rr = 0, rz, bsy;
    logic [15:0] id = 0, ain0, ain1, aout, rd_data;
    logic [2:0]  aop, rrd;
    logic        iv_b = 0, ir_b, rv_b, rr_b = 0, rz_b, bsy_b;
    logic [15:0] id_b = 0, ain0_b, ain1_b, aout_b, rd_data_b;
    logic [2:0]  aop_b, rrd_b;

    function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return ~a;
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return a ^ b;
            3'd6: return ~(a ^ b);
            default: return 16'h0;
        endcase
    endfunction
    assign aout   = alu(aop, ain0, ain1);
    assign aout_b = alu(aop_b, ain0_b, ain1_b);

    alu_sequencer #(.DATA_W(16), .EXEC_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(iv), .instr_ready(ir), .instr_data(id),
        .alu_op(aop), .alu_in0(ain0), .alu_in1(ain1), .alu_out(aout),
        .rsp_valid(rv), .rsp_ready(rr), .rsp_data(rd_data), .rsp_rd(rrd), .rsp_zero(rz), .busy(bsy));
    alu_sequencer #(.DATA_W(16), .EXEC_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .instr_valid(iv_b), .instr_ready(ir_b), .instr_data(id_b),
        .alu_op(aop_b), .alu_in0(ain0_b), .alu_in1(ain1_b), .alu_out(aout_b),
        .rsp_valid(rv_b), .rsp_ready(rr_b), .rsp_data(rd_data_b), .rsp_rd(rrd_b), .rsp_zero(rz_b), .busy(bsy_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] ai(input logic [2:0] op, rd, rs1, rs2);
        return {1'b0, op, rd, rs1, rs2, 3'b000};
    endfunction
    function automatic logic [15:0] li(input logic [2:0] rd, input logic [11:0] imm);
        return {1'b1, rd, imm};
    endfunction

    task automatic run(input string tag, input logic [15:0] ins, input logic [15:0] exp_d, input logic [2:0] exp_rd);
        int k;
        @(negedge clk);
        iv = 1; id = ins;
        k = 0;
        while (!ir && k < 20) begin @(negedge clk); k++; end
        @(posedge clk); #1 iv = 0;
        k = 0;
        while (!rv && k < 20) begin @(negedge clk); k++; end
        check({tag, "_lat"}, k, 2);
        check({tag, "_data"}, rd_data, exp_d);
        check({tag, "_rd"}, rrd, exp_rd);
        check({tag, "_zero"}, rz, exp_d == 0);
        rr = 1;
        @(posedge clk); #1 rr = 0;
    endtask

    initial begin
        int k, last, per_ok;
        #12;
        check("rst_valid", rv, 0);
        check("rst_data", rd_data, 0);
        check("rst_busy", bsy, 0);
        check("rst_alu_in0", ain0, 0);
        rst_n = 1;
        @(negedge clk);
        check("rst_ready", ir, 1);
        rr = 1;
        @(negedge clk);
        check("idle_rr_valid", rv, 0);
        check("idle_rr_busy", bsy, 0);
        rr = 0;

        run("ldi1", li(1, 5), 16'h0005, 1);
        run("ldi2", li(2, 3), 16'h0003, 2);
        run("add", ai(0, 3, 1, 2), 16'h0008, 3);
        run("sub", ai(1, 4, 2, 1), 16'hFFFE, 4);
        run("subz", ai(1, 5, 1, 1), 16'h0000, 5);
        run("not", ai(2, 6, 1, 0), 16'hFFFA, 6);
        run("and", ai(3, 4, 1, 2), 16'h0001, 4);
        run("or", ai(4, 4, 1, 2), 16'h0007, 4);
        run("xor", ai(5, 4, 1, 2), 16'h0006, 4);
        run("ldimax", li(4, 12'hFFF), 16'h0FFF, 4);

        @(negedge clk);
        iv = 1; id = ai(0, 3, 1, 2);
        @(posedge clk); #1 id = li(7, 12'h123);
        k = 0;
        while (!rv && k < 20) begin @(negedge clk); k++; end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", rv, 1);
            check("bp_data", rd_data, 16'h0008);
            check("bp_ready", ir, 0);
        end
        check("bp_rd", rrd, 3);
        iv = 0; rr = 1;
        @(posedge clk); #1 rr = 0;
        check("bp_exit_busy", bsy, 0);

        run("op7", ai(7, 3, 1, 2), 16'h0000, 3);
        run("op7_wb", ai(0, 5, 3, 1), 16'h0005, 5);
        run("xnor", ai(6, 7, 1, 1), 16'hFFFF, 7);
        run("rdsrc", ai(0, 1, 1, 1), 16'h000A, 1);

        run("ldi3", li(3, 9), 16'h0009, 3);
        @(negedge clk);
        iv = 1; id = ai(0, 3, 1, 2);
        @(posedge clk); #1 iv = 0;
        check("mid_busy", bsy, 1);
        rst_n = 0;
        #1;
        check("ar_valid", rv, 0);
        check("ar_busy", bsy, 0);
        check("ar_op", aop, 0);
        check("ar_in0", ain0, 0);
        check("ar_data", rd_data, 0);
        @(negedge clk); rst_n = 1;
        run("post_rst", ai(0, 4, 3, 3), 16'h0000, 4);
        run("post_rst2", ai(0, 4, 1, 2), 16'h0000, 4);

        rr = 1; iv = 1; id = li(2, 12'h0AB);
        last = -1; per_ok = 1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (ir) begin
                if (last >= 0) check("tput1_period", c - last, 3);
                last = c;
            end
            if (rv) check("tput1_data", rd_data, 16'h00AB);
        end
        check("tput1_seen", last >= 0, 1);
        iv = 0; rr = 0;
        @(negedge clk);

        rr_b = 1; iv_b = 1; id_b = li(6, 12'h5C3);
        last = -1;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            if (ir_b) begin
                if (last >= 0) check("tput3_period", c - last, 5);
                last = c;
            end
            if (bsy_b && !rv_b) begin
                check("tput3_in0", ain0_b, 16'h05C3);
                check("tput3_op", aop_b, 0);
            end
            if (rv_b) begin
                check("tput3_data", rd_data_b, 16'h05C3);
                check("tput3_rd", rrd_b, 6);
            end
        end
        check("tput3_seen", last >= 0, 1);
        iv_b = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
